// File: rtl/npm_toggle_cal_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : npm_toggle_cal_timer_responder
// Description : CAL/Timer primitive responder driving the Toggle NAND bus.
// Revision    : 1.0 - initial release
// ============================================================================
module npm_toggle_cal_timer_responder #(
    parameter int NumberOfWays   = 4,
    parameter int WE_LOW_CYCLES  = 2,
    parameter int WE_HIGH_CYCLES = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [7:0]              iPCommand,
    input  logic [2:0]              iPCommandOption,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic [15:0]             iNumOfData,
    input  logic                    iCASelect,
    input  logic [7:0]              iCAData,
    output logic [7:0]              oReady,
    output logic [7:0]              oLastStep,
    output logic [NumberOfWays-1:0] oCE_n,
    output logic                    oCLE,
    output logic                    oALE,
    output logic                    oWE_n,
    output logic [7:0]              oDQ,
    output logic                    oDQOE
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAL_SETUP = 3'd1,
        S_CAL_WEL   = 3'd2,
        S_CAL_WEH   = 3'd3,
        S_TIMER     = 3'd4
    } state_t;

    localparam logic [7:0]  c_CMD_CAL   = 8'h08;
    localparam logic [7:0]  c_CMD_TIMER = 8'h01;
    localparam logic [15:0] c_WEL_LAST  = 16'(WE_LOW_CYCLES - 1);
    localparam logic [15:0] c_WEH_LAST  = 16'(WE_HIGH_CYCLES - 1);

    state_t                  r_state;
    logic [15:0]             r_count;
    logic                    r_calPrime;
    logic [2:0]              r_emitIdx;
    logic [2:0]              r_emitLast;
    logic                    r_capActive;
    logic [2:0]              r_capIdx;
    logic [2:0]              r_capLast;
    logic [8:0]              r_caBuf [8];
    logic [7:0]              r_ready;
    logic [7:0]              r_lastStep;
    logic [NumberOfWays-1:0] r_ceN;
    logic                    r_cle;
    logic                    r_ale;
    logic                    r_weN;
    logic [7:0]              r_dq;
    logic                    r_dqoe;

    wire       w_acceptCal   = (r_state == S_IDLE) && (iPCommand == c_CMD_CAL);
    wire       w_acceptTimer = (r_state == S_IDLE) && (iPCommand == c_CMD_TIMER);
    wire       w_lastByte    = (r_emitIdx == r_emitLast);
    wire [8:0] w_nextByte    = r_caBuf[r_emitIdx + 3'd1];
    wire       w_unused      = &{1'b0, iPCommandOption[2:1]};

    // Byte capture runs on its own index, one byte per cycle, ahead of emission.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            r_capActive <= 1'b0;
            r_capIdx    <= 3'd0;
            r_capLast   <= 3'd0;
            for (int i = 0; i < 8; i++) r_caBuf[i] <= 9'd0;
        end else if (w_acceptCal) begin
            r_capActive <= 1'b1;
            r_capIdx    <= 3'd0;
            r_capLast   <= iNumOfData[2:0];
        end else if (r_capActive) begin
            r_caBuf[r_capIdx] <= {iCASelect, iCAData};
            if (r_capIdx == r_capLast) r_capActive <= 1'b0;
            else                       r_capIdx    <= r_capIdx + 3'd1;
        end
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            r_state    <= S_IDLE;
            r_count    <= 16'd0;
            r_calPrime <= 1'b0;
            r_emitIdx  <= 3'd0;
            r_emitLast <= 3'd0;
            r_ready    <= 8'hFF;
            r_lastStep <= 8'h00;
            r_ceN      <= '1;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_weN      <= 1'b1;
            r_dq       <= 8'h00;
            r_dqoe     <= 1'b0;
        end else begin
            r_lastStep <= 8'h00;
            case (r_state)
                S_IDLE: begin
                    if (w_acceptCal) begin
                        r_state    <= S_CAL_SETUP;
                        r_calPrime <= 1'b1;
                        r_emitIdx  <= 3'd0;
                        r_emitLast <= iNumOfData[2:0];
                        r_ready    <= 8'h00;
                        r_ceN      <= ~iTargetWay;
                    end else if (w_acceptTimer) begin
                        r_state       <= S_TIMER;
                        r_count       <= iNumOfData;
                        r_ready       <= 8'h00;
                        r_ceN         <= iPCommandOption[0] ? ~iTargetWay : '1;
                        r_lastStep[0] <= (iNumOfData == 16'd0);
                    end
                end
                S_CAL_SETUP: begin
                    // Priming cycle: byte 0 is taken straight from the bus as it is captured.
                    if (r_calPrime) begin
                        r_calPrime <= 1'b0;
                        r_dq       <= iCAData;
                        r_cle      <= ~iCASelect;
                        r_ale      <= iCASelect;
                        r_dqoe     <= 1'b1;
                    end else begin
                        r_state <= S_CAL_WEL;
                        r_weN   <= 1'b0;
                        r_count <= c_WEL_LAST;
                    end
                end
                S_CAL_WEL: begin
                    if (r_count == 16'd0) begin
                        r_state       <= S_CAL_WEH;
                        r_weN         <= 1'b1;
                        r_count       <= c_WEH_LAST;
                        r_lastStep[3] <= w_lastByte && (c_WEH_LAST == 16'd0);
                    end else begin
                        r_count <= r_count - 16'd1;
                    end
                end
                S_CAL_WEH: begin
                    if (r_count != 16'd0) begin
                        r_count       <= r_count - 16'd1;
                        r_lastStep[3] <= w_lastByte && (r_count == 16'd1);
                    end else if (w_lastByte) begin
                        r_state <= S_IDLE;
                        r_ready <= 8'hFF;
                        r_ceN   <= '1;
                        r_cle   <= 1'b0;
                        r_ale   <= 1'b0;
                        r_dq    <= 8'h00;
                        r_dqoe  <= 1'b0;
                    end else begin
                        r_state   <= S_CAL_SETUP;
                        r_emitIdx <= r_emitIdx + 3'd1;
                        r_dq      <= w_nextByte[7:0];
                        r_cle     <= ~w_nextByte[8];
                        r_ale     <= w_nextByte[8];
                    end
                end
                S_TIMER: begin
                    if (r_count == 16'd0) begin
                        r_state <= S_IDLE;
                        r_ready <= 8'hFF;
                        r_ceN   <= '1;
                    end else begin
                        r_count       <= r_count - 16'd1;
                        r_lastStep[0] <= (r_count == 16'd1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oReady    = r_ready;
    assign oLastStep = r_lastStep;
    assign oCE_n     = r_ceN;
    assign oCLE      = r_cle;
    assign oALE      = r_ale;
    assign oWE_n     = r_weN;
    assign oDQ       = r_dq;
    assign oDQOE     = r_dqoe;

endmodule
`default_nettype wire
